uart_rx_buffer: RTL

Receive-side elastic buffer directly downstream of the UART receiver. It captures every received byte and every reported line error into a small synchronous FIFO, tagging each entry with its 2-bit error code. A downstream consumer, such as the command/VGA logic, drains entries over a valid/ready handshake. Overflow is detected, counted and flagged, never silently corrupting stored entries.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_buffer_mem.sv | 35 +++
 rtl/uart_rx_buffer.sv | 114 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: line error codes and the packed layout of a
// received entry (byte in [9:2], error code in [1:0]).
package uart_pkg;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_PARITY  = 2'b01;
  localparam logic [1:0] ERR_FRAMING = 2'b10;
  localparam logic [1:0] ERR_BREAK   = 2'b11;

  localparam int ENTRY_W = 10;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] err;
  } rx_entry_t;

  function automatic rx_entry_t make_entry(input logic [7:0] data, input logic [1:0] err);
    rx_entry_t e;
    e.data = data;
    e.err  = err;
    return e;
  endfunction

endpackage

// File: rtl/uart_rx_buffer_mem.sv
// DEPTH x ENTRY_W register array: one synchronous write port, one
// asynchronous read port. Cleared on reset so the head reads zero.
module uart_rx_buffer_mem
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [ENTRY_W-1:0] rdata
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (rst) begin
          mem_q[gi] <= '0;
        end else if (we && (waddr == AW'(gi))) begin
          mem_q[gi] <= wdata;
        end
      end
    end
  endgenerate

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_rx_buffer.sv
// Elastic FIFO behind the UART receiver: stores bytes and line errors,
// show-ahead output with valid/ready, sticky overflow and saturating drop count.
module uart_rx_buffer
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  input  logic [1:0]    in_error,
  input  logic          in_error_valid,
  output logic [7:0]    out_data,
  output logic [1:0]    out_error,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW:0]   level,
  output logic          full,
  output logic          overflow,
  output logic [7:0]    ovf_count,
  input  logic          ovf_clr
);

  localparam logic [AW:0]   LEVEL_FULL = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   LEVEL_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          full_q, full_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    ovf_count_q, ovf_count_d;

  logic      push_req, push_acc, pop, drop;
  rx_entry_t wr_entry, rd_entry;

  assign push_req = in_valid | in_error_valid;
  // out_valid comes from registered level only, so out_ready never reaches an output
  assign out_valid = (level_q != '0);
  assign pop       = out_valid & out_ready;
  // When full, a same-cycle pop frees the slot the push writes into
  assign push_acc  = push_req & (~full_q | pop);
  assign drop      = push_req & full_q & ~pop;

  assign wr_entry = make_entry(in_valid ? in_data : 8'h00,
                               in_error_valid ? in_error : ERR_NONE);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    overflow_d  = overflow_q;
    ovf_count_d = ovf_count_q;

    if (push_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)      rd_ptr_d = rd_ptr_q + PTR_ONE;

    if (push_acc && !pop)      level_d = level_q + LEVEL_ONE;
    else if (!push_acc && pop) level_d = level_q - LEVEL_ONE;

    if (drop) begin
      overflow_d  = 1'b1;
      if (ovf_clr)                  ovf_count_d = 8'd1;
      else if (ovf_count_q != 8'hFF) ovf_count_d = ovf_count_q + 8'd1;
    end else if (ovf_clr) begin
      overflow_d  = 1'b0;
      ovf_count_d = 8'd0;
    end

    full_d = (level_d == LEVEL_FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      full_q      <= 1'b0;
      overflow_q  <= 1'b0;
      ovf_count_q <= 8'd0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      full_q      <= full_d;
      overflow_q  <= overflow_d;
      ovf_count_q <= ovf_count_d;
    end
  end

  uart_rx_buffer_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (push_acc),
    .waddr (wr_ptr_q),
    .wdata (wr_entry),
    .raddr (rd_ptr_q),
    .rdata (rd_entry)
  );

  assign out_data  = rd_entry.data;
  assign out_error = rd_entry.err;
  assign level     = level_q;
  assign full      = full_q;
  assign overflow  = overflow_q;
  assign ovf_count = ovf_count_q;

endmodule
